// File: rtl/axis_dwidth_pkg.sv
// Shared AXI4-Stream width-conversion helpers.
// Used by both the upsizer and the downsizer.
package axis_dwidth_pkg;

  typedef enum logic {
    EMPTY,
    SEND
  } state_e;

  localparam int SLICE_MAX = 1024;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Slice k counts from the most-significant end of the wide word
  function automatic logic [SLICE_MAX-1:0] slice(
    input logic [SLICE_MAX-1:0] data,
    input int                   k,
    input int                   width,
    input int                   num_reg
  );
    logic [SLICE_MAX-1:0] mask;
    mask = {SLICE_MAX{1'b1}} >> (SLICE_MAX - width);
    return (data >> (width * (num_reg - 1 - k))) & mask;
  endfunction

endpackage

// File: rtl/my_axis_dwidth_downsize.sv
// AXI4-Stream downsizer: one wide beat in, NUM_REG narrow
// beats out, most-significant slice first.
module my_axis_dwidth_downsize
  import axis_dwidth_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REG = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [WIDTH*NUM_REG-1:0] s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic                     m_axis_tlast
);

  localparam int IW = idx_w(NUM_REG);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REG - 1);

  state_e                   state;
  logic [WIDTH*NUM_REG-1:0] data_q;
  logic                     last_q;
  logic [IW-1:0]            idx;

  logic last_slice;
  logic s_hs;
  logic m_hs;

  always_comb begin
    last_slice    = (idx == LAST_IDX);
    m_axis_tvalid = (state == SEND);
    m_hs          = m_axis_tvalid && m_axis_tready;
    s_axis_tready = !areset &&
                    ((state == EMPTY) || (m_hs && last_slice));
    s_hs          = s_axis_tvalid && s_axis_tready;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (m_axis_tvalid) begin
      m_axis_tdata = WIDTH'(slice(SLICE_MAX'(data_q),
                                  int'(idx), WIDTH, NUM_REG));
      m_axis_tlast = last_q && last_slice;
    end
  end

  // A new wide beat may replace the held one on its final slice
  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= EMPTY;
      data_q <= '0;
      last_q <= 1'b0;
      idx    <= '0;
    end else if (s_hs) begin
      state  <= SEND;
      data_q <= s_axis_tdata;
      last_q <= s_axis_tlast;
      idx    <= '0;
    end else if (m_hs) begin
      if (last_slice) begin
        state <= EMPTY;
        idx   <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_my_axis_dwidth_downsize.sv
// Scoreboard bench for the AXI4-Stream downsizer.
// Two instances: 32x2 and 8x4.
module tb_my_axis_dwidth_downsize;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int W2 = 8;
  localparam int N2 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_valid, s_ready, s_last;
  logic [63:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;

  logic        s_valid_b, s_ready_b, s_last_b;
  logic [31:0] s_data_b;
  logic        m_valid_b, m_ready_b, m_last_b;
  logic [7:0]  m_data_b;

  my_axis_dwidth_downsize #(.WIDTH(W), .NUM_REG(N)) dut (
    .aclk(clk), .areset(rst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tdata(s_data), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tdata(m_data), .m_axis_tlast(m_last)
  );

  my_axis_dwidth_downsize #(.WIDTH(W2), .NUM_REG(N2)) dut_b (
    .aclk(clk), .areset(rst),
    .s_axis_tvalid(s_valid_b), .s_axis_tready(s_ready_b),
    .s_axis_tdata(s_data_b), .s_axis_tlast(s_last_b),
    .m_axis_tvalid(m_valid_b), .m_axis_tready(m_ready_b),
    .m_axis_tdata(m_data_b), .m_axis_tlast(m_last_b)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t q[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mode = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Reference: wide word split into equal parts, MS part first
  task automatic push_exp(input logic [63:0] d, input logic l);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.d = 32'(d >> (W * (N - 1 - k)));
      e.l = l && (k == N - 1);
      q.push_back(e);
    end
  endtask

  task automatic push_exp_b(input logic [31:0] d, input logic l);
    exp_t e;
    for (int k = 0; k < N2; k++) begin
      e.d = 32'((d / (32'd1 << (W2 * (N2 - 1 - k)))) % 256);
      e.l = l && (k == N2 - 1);
      qb.push_back(e);
    end
  endtask

  task automatic put(input logic [63:0] d, input logic l,
                     output int acc);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    acc     = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_ready) begin
        push_exp(d, l);
        acc = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_data  = {$urandom, $urandom};
    s_last  = 1'($urandom);
    if (acc < 0) check("put_timeout", 0, 1);
  endtask

  task automatic put_b(input logic [31:0] d, input logic l);
    int acc;
    s_valid_b = 1'b1;
    s_data_b  = d;
    s_last_b  = l;
    acc       = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_ready_b) begin
        push_exp_b(d, l);
        acc = n;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid_b = 1'b0;
    s_data_b  = $urandom;
    if (acc < 0) check("put_b_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && qb.size() == 0) break;
    end
    check("drain_a", q.size(), 0);
    check("drain_b", qb.size(), 0);
  endtask

  always begin
    @(posedge clk); #1;
    if (mode == 0) m_ready = 1'b1;
    else if (mode == 1) m_ready = ($urandom % 4) != 0;
  end

  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_s_ready", s_ready, 0);
      if (rst_seen) begin
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
      end
      q.delete();
      qb.delete();
      pv <= 1'b0;
    end else begin
      if (pv && !pr) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, pd);
        check("stall_last", m_last, pl);
      end
      if (m_valid && !m_ready) check("stall_s_ready", s_ready, 0);
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          check("m_data", m_data, e.d);
          check("m_last", m_last, e.l);
        end
      end
      if (m_valid_b && m_ready_b) begin
        if (qb.size() == 0) begin
          check("unexpected_beat_b", 1, 0);
        end else begin
          e = qb.pop_front();
          check("m_data_b", m_data_b, e.d);
          check("m_last_b", m_last_b, e.l);
        end
      end
      pv <= m_valid;
      pr <= m_ready;
      pd <= m_data;
      pl <= m_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc[4];
    int a;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    m_ready   = 1'b1;
    s_valid_b = 1'b0;
    s_data_b  = '0;
    s_last_b  = 1'b0;
    m_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_release", s_ready, 1);
    check("idle_m_valid", m_valid, 0);
    @(posedge clk); #1;

    put(64'hAAAA_AAAA_5555_5555, 1'b1, a);
    @(negedge clk);
    check("first_beat_latency", m_valid, 1);
    drain(50);

    for (int i = 0; i < 4; i++)
      put({$urandom, $urandom}, i == 3, acc[i]);
    for (int i = 1; i < 4; i++)
      check("b2b_accept_spacing", acc[i] - acc[i-1], 2);
    drain(50);

    mode = 2;
    m_ready = 1'b1;
    fork
      begin
        put(64'h0123_4567_89AB_CDEF, 1'b0, a);
        put(64'hFEDC_BA98_7654_3210, 1'b1, a);
      end
      begin
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        check("bp_s_ready_low", s_ready, 0);
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    mode = 0;
    drain(50);

    put(64'h1111_2222_3333_4444, 1'b1, a);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_mid_reset", s_ready, 1);
    @(posedge clk); #1;
    put(64'h5A5A_0F0F_C3C3_9696, 1'b1, a);
    drain(50);

    put_b(32'hDEAD_BEEF, 1'b1);
    put_b($urandom, 1'b0);
    put_b($urandom, 1'b1);
    drain(50);

    mode = 1;
    for (int i = 0; i < 60; i++) begin
      put({$urandom, $urandom}, 1'($urandom), a);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain(500);
    mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
